// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter: packet-granular round-robin merge of NPORTS transmit streams
// onto one registered 64-bit output stream.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       - per-requester beat handshake
//   in_bits_data/keep/last  - per-requester beat payload, requester i in slice i
//   net_out_valid/ready     - merged output handshake (registered output stage)
//   net_out_bits_data/keep/last - merged beat payload
//   grant                   - one-hot owner of the current packet, zero when idle
//   busy                    - high while a packet owns the output
module net_tx_arbiter #(
    parameter int unsigned NPORTS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      in_valid,
    output logic [NPORTS-1:0]      in_ready,
    input  logic [64*NPORTS-1:0]   in_bits_data,
    input  logic [8*NPORTS-1:0]    in_bits_keep,
    input  logic [NPORTS-1:0]      in_bits_last,
    output logic                   net_out_valid,
    input  logic                   net_out_ready,
    output logic [63:0]            net_out_bits_data,
    output logic [7:0]             net_out_bits_keep,
    output logic                   net_out_bits_last,
    output logic [NPORTS-1:0]      grant,
    output logic                   busy
);

    localparam int unsigned PW = $clog2(NPORTS);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     owner_q;
    logic [NPORTS-1:0] grant_q;
    logic              out_full_q;
    logic [63:0]       out_data_q;
    logic [7:0]        out_keep_q;
    logic              out_last_q;

    logic              slot_free;
    logic              transfer;
    logic [63:0]       sel_data;
    logic [7:0]        sel_keep;
    logic              sel_last;
    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [NPORTS-1:0] pick_onehot;
    int unsigned       cand_w;

    // The output slot can take a beat if empty or draining this cycle.
    assign slot_free = !out_full_q | net_out_ready;
    assign in_ready  = (state_q == StLocked && slot_free) ? grant_q : '0;
    assign transfer  = |(in_valid & in_ready);

    // Payload of the granted requester; grant_q is one-hot so at most one hit.
    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_q[i]) begin
                sel_data = in_bits_data[64*i +: 64];
                sel_keep = in_bits_keep[8*i +: 8];
                sel_last = in_bits_last[i];
            end
        end
    end

    // Round-robin search: first valid requester at or after ptr_q, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_w     = 0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            cand_w = 32'(ptr_q) + k;
            if (cand_w >= NPORTS) begin
                cand_w = cand_w - NPORTS;
            end
            if (!pick_found && in_valid[cand_w[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_w[PW-1:0];
            end
        end
    end

    assign pick_onehot = NPORTS'(1) << pick_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            out_full_q <= 1'b0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_q <= pick_onehot;
                        owner_q <= pick_idx;
                        state_q <= StLocked;
                    end
                end
                StLocked: begin
                    // Owner keeps the grant through any valid gaps until its last beat.
                    if (transfer && sel_last) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                        ptr_q   <= (owner_q == PW'(NPORTS - 1)) ? '0 : owner_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A load wins over a drain, so back-to-back beats keep the slot full.
            if (transfer) begin
                out_full_q <= 1'b1;
                out_data_q <= sel_data;
                out_keep_q <= sel_keep;
                out_last_q <= sel_last;
            end else if (net_out_ready) begin
                out_full_q <= 1'b0;
            end
        end
    end

    assign grant             = grant_q;
    assign busy              = (state_q == StLocked);
    assign net_out_valid     = out_full_q;
    assign net_out_bits_data = out_data_q;
    assign net_out_bits_keep = out_keep_q;
    assign net_out_bits_last = out_last_q;

endmodule

// File: doc/net_tx_arbiter.md
NET_TX_ARBITER -- requirements
Module: net_tx_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 4, meaning number of requesting transmit streams (2..8).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  in  NPORTS  per-requester beat valid.
REQ-005 SHALL have port in_ready  out  NPORTS  per-requester beat accepted.
REQ-006 SHALL have port in_bits_data  in  64*NPORTS  beat data, requester i at bits [64i+63:64i].
REQ-007 SHALL have port in_bits_keep  in  8*NPORTS  byte enables, requester i at bits [8i+7:8i].
REQ-008 SHALL have port in_bits_last  in  NPORTS  final beat of packet.
REQ-009 SHALL have port net_out_valid  out  1  merged stream valid.
REQ-010 SHALL have port net_out_ready  in  1  downstream network interface ready.
REQ-011 SHALL have port net_out_bits_data  out  64  merged beat data.
REQ-012 SHALL have port net_out_bits_keep  out  8  merged byte enables, passed through unmodified.
REQ-013 SHALL have port net_out_bits_last  out  1  merged end-of-packet.
REQ-014 SHALL have port grant  out  NPORTS  one-hot current owner; all zero when idle.
REQ-015 SHALL have port busy  out  1  high while a packet is locked.

Function
REQ-016 SHALL arbitrate at packet granularity; beats of different packets never interleave on the output.
REQ-017 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-018 In IDLE, with any in_valid high, SHALL select the first requester with in_valid set, searching from index ptr upward and wrapping modulo NPORTS, register it into grant, and enter LOCKED on that edge.
REQ-019 In IDLE, SHALL hold in_ready all zero, giving one arbitration bubble cycle per packet.
REQ-020 In LOCKED, SHALL drive in_ready[g] = slot_free for granted index g and 0 for all others, where slot_free = !out_full | net_out_ready.
REQ-021 A transfer SHALL occur when in_valid[g] & in_ready[g]; data, keep and last load into the output register on that edge.
REQ-022 On a transfer with in_bits_last[g]=1, SHALL return to IDLE, clear grant, and set ptr = (g+1) mod NPORTS.
REQ-023 While LOCKED, SHALL hold grant when the owner deasserts in_valid mid-packet; there is no timeout.
REQ-024 Output register: net_out_valid = out_full; out_full sets on a transfer and clears on net_out_ready & !transfer; on a simultaneous drain and load it stays set with the new beat.
REQ-025 Full throughput SHALL be one beat per cycle within a packet when net_out_ready stays high.
REQ-026 Latency from input transfer to net_out_valid SHALL be exactly one cycle.
REQ-027 net_out_bits_* SHALL hold stable while net_out_valid & !net_out_ready.
REQ-028 A single-beat packet (first beat has last=1) SHALL return the FSM to IDLE on its transfer edge.
REQ-029 A requester not granted SHALL never see in_ready high, regardless of its in_valid.
REQ-030 busy SHALL equal (state == LOCKED).

Reset
REQ-031 Reset assertion SHALL immediately force state IDLE, ptr 0, grant 0, busy 0, in_ready 0, out_full 0, net_out_valid 0, and net_out_bits_data/keep/last 0.
REQ-032 Reset mid-packet SHALL discard the held output beat and the partial packet; the first edge after reset deassertion performs IDLE arbitration from ptr 0.

Verification
REQ-033 Requesters 0 and 2 each present a 3-beat packet in the same cycle, with net_out_ready=1 -> port 0 packet out first, one bubble, then port 2; ptr ends at 3.
REQ-034 All 4 ports continuously valid with 1-beat packets -> grant order 0,1,2,3,0, and each beat is followed by one idle cycle.
REQ-035 Port 1 sends data 0x1111_2222_3333_4444 with keep 0x0F and last=1, while net_out_ready is held 0 for 5 cycles -> output is stable and valid for 5 cycles, in_ready[1]=0 after the first beat, and the beat is delivered intact.
REQ-036 Port 3 drops in_valid for 4 cycles after beat 2 of 4 while port 0 is valid -> grant stays 4'b1000 and port 0 waits until port 3's last beat is transferred.
REQ-037 Reset is asserted while LOCKED with out_full=1 -> all outputs are 0 asynchronously, and after release the first grant goes to the lowest-index valid requester.
